rr_grant_ctrl: RTL and testbench

- Sequential round-robin arbitration controller for 8 requesters.
- Holds the rotating priority pointer and searches the request vector from it, using the team's programmable-priority rule:
  - the first set bit at or above the pointer wins, wrapping past bit 7;
  - a zero flag is raised when no bit is set.
- Registers the winner, holds the grant until it is released, then advances the pointer past the winner so service is fair.
- Sits directly downstream of the request-collection logic and feeds grant information to the shared-resource mux.

---
 rtl/rr_grant_if.sv | 36 +++
 rtl/rr_grant_ctrl.sv | 134 +++++++++++++
 tb/tb_rr_grant_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rr_grant_if.sv
// rr_grant_if -- request/grant bundle between the request-collection logic,
// the round-robin arbiter and the shared-resource mux.
//
// Signals:
//   req        [7:0] level request lines, bit i = requester i
//   done             current owner releases its grant
//   pri        [2:0] rotating priority pointer (search start index)
//   gnt_valid        a grant is active
//   gnt_idx    [2:0] index of the granted requester
//   gnt_onehot [7:0] one-hot form of gnt_idx, zero when no grant
//   zero             no request present this cycle
//   timeout          one-cycle pulse on a forced release
//
// Modports:
//   master -- requester side: drives req/done, observes grant information
//   slave  -- arbiter side:   observes req/done, drives grant information
interface rr_grant_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] pri;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       zero;
  logic       timeout;

  modport master (
    output req, done,
    input  pri, gnt_valid, gnt_idx, gnt_onehot, zero, timeout
  );

  modport slave (
    input  req, done,
    output pri, gnt_valid, gnt_idx, gnt_onehot, zero, timeout
  );
endinterface

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl -- sequential round-robin arbiter for 8 requesters.
//
// Searches req starting at the rotating pointer pri (wrapping past bit 7),
// registers the winner, holds the grant until the owner asserts done or
// drops its request, then moves pri to one past the winner.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_grant_if.slave (req, done in; pri, gnt_valid, gnt_idx,
//          gnt_onehot, zero, timeout out)
//
// Parameters:
//   HOLD_MAX  maximum grant length in cycles, 1..15 (timeout build only)
//
// Configuration macro:
//   RR_TIMEOUT_EN  when defined, a grant is force-released after HOLD_MAX
//                  cycles and timeout pulses; when undefined, timeout is 0.
module rr_grant_ctrl #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_grant_if.slave  bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold_max
    $error("rr_grant_ctrl: HOLD_MAX must be in 1..15");
  end

  state_t     r_state;
  logic [2:0] r_pri;
  logic       r_gnt_valid;
  logic [2:0] r_gnt_idx;
  logic [7:0] r_gnt_onehot;

  logic [2:0] w_win_idx;
  logic       w_any_req;
  logic       w_owner_drop;
  logic       w_tmo_hit;
  logic       w_release;

  // Programmable-priority search: first set bit at or above r_pri, wrapping.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    w_win_idx = r_pri;
    found     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = r_pri + 3'(k);
      if (!found && bus.req[idx]) begin
        w_win_idx = idx;
        found     = 1'b1;
      end
    end
  end

  assign w_any_req    = |bus.req;
  assign w_owner_drop = !bus.req[r_gnt_idx];

`ifdef RR_TIMEOUT_EN
  logic [3:0] r_hold;
  logic       r_timeout;

  assign w_tmo_hit   = (r_hold == 4'(HOLD_MAX - 1));
  assign bus.timeout = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= 4'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == S_IDLE) begin
        r_hold <= 4'd0;
      end else begin
        if (r_hold != 4'hF) r_hold <= r_hold + 4'd1;
        // Pulse only when the limit is the sole reason for the release.
        r_timeout <= w_tmo_hit && !bus.done && !w_owner_drop;
      end
    end
  end
`else
  assign w_tmo_hit   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign w_release = bus.done || w_owner_drop || w_tmo_hit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pri        <= 3'd0;
      r_gnt_valid  <= 1'b0;
      r_gnt_idx    <= 3'd0;
      r_gnt_onehot <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state      <= S_GRANT;
            r_gnt_valid  <= 1'b1;
            r_gnt_idx    <= w_win_idx;
            r_gnt_onehot <= 8'b1 << w_win_idx;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_state      <= S_IDLE;
            r_gnt_valid  <= 1'b0;
            r_gnt_onehot <= 8'd0;
            r_pri        <= r_gnt_idx + 3'd1;  // 7 wraps to 0
          end
        end
      endcase
    end
  end

  assign bus.pri        = r_pri;
  assign bus.gnt_valid  = r_gnt_valid;
  assign bus.gnt_idx    = r_gnt_idx;
  assign bus.gnt_onehot = r_gnt_onehot;
  assign bus.zero       = (bus.req == 8'd0);

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl -- directed bench for rr_grant_ctrl (HOLD_MAX = 4).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, well away from the next edge.
module tb_rr_grant_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rr_grant_if bus ();

  rr_grant_ctrl #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx, input logic [2:0] pri);
    check({tag, " valid"},   8'(bus.gnt_valid),  8'd1);
    check({tag, " idx"},     8'(bus.gnt_idx),    8'(idx));
    check({tag, " onehot"},  bus.gnt_onehot,     8'b1 << idx);
    check({tag, " pri"},     8'(bus.pri),        8'(pri));
  endtask

  task automatic check_idle(input string tag, input logic [2:0] pri);
    check({tag, " valid"},  8'(bus.gnt_valid), 8'd0);
    check({tag, " onehot"}, bus.gnt_onehot,    8'd0);
    check({tag, " pri"},    8'(bus.pri),       8'(pri));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req  = 8'd0;
    bus.done = 1'b0;

    // Reset values
    #2;
    check_idle("reset", 3'd0);
    check("reset idx",     8'(bus.gnt_idx), 8'd0);
    check("reset timeout", 8'(bus.timeout), 8'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle zero", 8'(bus.zero), 8'd1);
      check_idle("idle", 3'd0);
    end

    // Single request, done release
    bus.req = 8'b0000_0001;
    #1 check("zero drops", 8'(bus.zero), 8'd0);
    tick();
    check_grant("single", 3'd0, 3'd0);
    bus.done = 1'b1;
    tick();
    check_idle("single rel", 3'd1);

    // Fairness: done held, req 00100011 held, starting pri=1
    bus.req = 8'b0010_0011;
    tick(); check_grant("fair g1", 3'd1, 3'd1);
    tick(); check_idle("fair r1", 3'd2);
    tick(); check_grant("fair g5", 3'd5, 3'd2);
    tick(); check_idle("fair r5", 3'd6);
    tick(); check_grant("fair g0", 3'd0, 3'd6);
    tick(); check_idle("fair r0", 3'd1);
    tick(); check_grant("fair g1b", 3'd1, 3'd1);
    tick(); check_idle("fair r1b", 3'd2);

    // Wrap: grant 6, then search 7 -> 0 -> ... -> 3
    bus.done = 1'b0;
    bus.req  = 8'b0100_0000;
    tick(); check_grant("wrap g6", 3'd6, 3'd2);
    bus.done = 1'b1;
    tick(); check_idle("wrap r6", 3'd7);
    bus.done = 1'b0;
    bus.req  = 8'b0100_1000;
    tick(); check_grant("wrap g3", 3'd3, 3'd7);
    bus.done = 1'b1;
    tick(); check_idle("wrap r3", 3'd4);
    bus.done = 1'b0;

    // Other requests ignored during a grant; owner drop releases
    bus.req = 8'b0001_0000;
    tick(); check_grant("drop g4", 3'd4, 3'd4);
    bus.req = 8'b0001_1000;
    tick(); check_grant("ignore", 3'd4, 3'd4);
    bus.req = 8'b0000_1000;
    tick(); check_idle("drop r4", 3'd5);
    tick(); check_grant("drop g3", 3'd3, 3'd5);
    bus.req = 8'd0;
    tick(); check_idle("drop r3", 3'd4);

    // Hold limit: done stays low, req[2] held
    bus.req = 8'b0000_0100;
    tick(); check_grant("hold t0", 3'd2, 3'd4);
    check("hold t0 tmo", 8'(bus.timeout), 8'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_grant("hold", 3'd2, 3'd4);
      check("hold tmo", 8'(bus.timeout), 8'd0);
    end
    tick();
`ifdef RR_TIMEOUT_EN
    check_idle("tmo rel", 3'd3);
    check("tmo pulse", 8'(bus.timeout), 8'd1);
    tick();
    check("tmo one cycle", 8'(bus.timeout), 8'd0);
    check_grant("tmo regrant", 3'd2, 3'd3);
`else
    check_grant("no tmo t4", 3'd2, 3'd4);
    check("no tmo t4 tmo", 8'(bus.timeout), 8'd0);
    tick();
    check_grant("no tmo t5", 3'd2, 3'd4);
`endif
    bus.req = 8'd0;
    tick(); check_idle("hold drop", 3'd3);
    check("hold drop tmo", 8'(bus.timeout), 8'd0);

    // Mid-grant asynchronous reset
    bus.req = 8'b0010_0000;
    tick(); check_grant("mid g5", 3'd5, 3'd3);
    rst_n = 1'b0;
    #1;
    check_idle("async rst", 3'd0);
    check("async rst idx",  8'(bus.gnt_idx), 8'd0);
    check("async rst tmo",  8'(bus.timeout), 8'd0);
    check("async rst zero", 8'(bus.zero),    8'd0);
    #1 rst_n = 1'b1;
    tick(); check_grant("post rst g5", 3'd5, 3'd0);
    bus.done = 1'b1;
    tick(); check_idle("post rst rel", 3'd6);
    bus.done = 1'b0;
    bus.req  = 8'd0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
